// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared constants and enums for the game driver slice
package game_pkg;

    localparam int COUNTER_SIZE = 4;

    typedef enum logic {
        OP_INIT = 1'b0,
        OP_RUN  = 1'b1
    } cmd_op_e;

    typedef enum logic [1:0] {
        UP1 = 2'b00,
        UP2 = 2'b01,
        DN1 = 2'b10,
        DN2 = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        OVER = 2'b11
    } state_e;

endpackage

// File: rtl/game_sat_counter.sv
// rtl/game_sat_counter.sv - 4-bit saturating event counter with synchronous clear
//
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clr        : clear the count to 0 at the end of this cycle
//   inc        : count one event this cycle (holds at 15)
//   count      : current count
module game_sat_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= 4'd0;
        end else if (inc && count != 4'hF) begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/game_driver.sv
// rtl/game_driver.sv - command-driven sequencer for the game block with win/loss observation
//
// Ports:
//   clk, reset                      : clock and synchronous active-high reset
//   cmd_valid/cmd_ready             : command handshake (ready only in IDLE)
//   cmd_op, cmd_mode, cmd_value     : INIT load value or RUN mode and length
//   init, i_value, control          : drive to the game block
//   win, los, gameover, who         : status from the game block
//   busy, done, result              : progress, completion pulse, latched winner
//   obs_wins, obs_losses            : saturating win/loss counts since last clear
module game_driver
    import game_pkg::*;
#(
    parameter int COUNTER_SIZE = game_pkg::COUNTER_SIZE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_op,
    input  logic [1:0]              cmd_mode,
    input  logic [COUNTER_SIZE-1:0] cmd_value,
    output logic                    init,
    output logic [COUNTER_SIZE-1:0] i_value,
    output logic [1:0]              control,
    input  logic                    win,
    input  logic                    los,
    input  logic                    gameover,
    input  logic [1:0]              who,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              result,
    output logic [3:0]              obs_wins,
    output logic [3:0]              obs_losses
);

    state_e                  state;
    // Cycles left in RUN including the current one; 0 encodes the full 2^N span.
    logic [COUNTER_SIZE-1:0] remaining;
    logic                    last_cycle;
    logic                    obs_clr;

    assign last_cycle = (remaining == COUNTER_SIZE'(1));
    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    // gameover in the final RUN cycle wins over expiry, so it masks the run's done.
    assign done       = (state == LOAD) || (state == OVER) ||
                        ((state == RUN) && last_cycle && !gameover);
    assign obs_clr    = (state == LOAD) || (state == OVER);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            init      <= 1'b0;
            i_value   <= '0;
            control   <= UP1;
            result    <= 2'b00;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_op == OP_INIT) begin
                            state   <= LOAD;
                            init    <= 1'b1;
                            i_value <= cmd_value;
                        end else begin
                            state     <= RUN;
                            control   <= cmd_mode;
                            remaining <= cmd_value;
                        end
                    end
                end
                LOAD: begin
                    init  <= 1'b0;
                    state <= IDLE;
                end
                RUN: begin
                    if (gameover) begin
                        state  <= OVER;
                        result <= who;
                    end else if (last_cycle) begin
                        state <= IDLE;
                    end else begin
                        remaining <= remaining - COUNTER_SIZE'(1);
                    end
                end
                OVER: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    game_sat_counter u_wins (
        .clk   (clk),
        .reset (reset),
        .clr   (obs_clr),
        .inc   ((state == RUN) && win),
        .count (obs_wins)
    );

    game_sat_counter u_losses (
        .clk   (clk),
        .reset (reset),
        .clr   (obs_clr),
        .inc   ((state == RUN) && los),
        .count (obs_losses)
    );

endmodule

// File: tb/tb_game_driver.sv
// tb/tb_game_driver.sv - scoreboard bench for game_driver with randomized commands
module tb_game_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_op = 1'b0;
    logic [1:0] cmd_mode = 2'b00;
    logic [3:0] cmd_value = 4'd0;
    logic       init;
    logic [3:0] i_value;
    logic [1:0] control;
    logic       win = 1'b0;
    logic       los = 1'b0;
    logic       gameover = 1'b0;
    logic [1:0] who = 2'b00;
    logic       busy;
    logic       done;
    logic [1:0] result;
    logic [3:0] obs_wins;
    logic [3:0] obs_losses;

    game_driver #(.COUNTER_SIZE(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_mode(cmd_mode), .cmd_value(cmd_value),
        .init(init), .i_value(i_value), .control(control),
        .win(win), .los(los), .gameover(gameover), .who(who),
        .busy(busy), .done(done), .result(result),
        .obs_wins(obs_wins), .obs_losses(obs_losses)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         delta;
        logic       init;
        logic [3:0] ival;
        logic [1:0] ctrl;
        logic [1:0] res;
        int         wins;
        int         losses;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   accept_cyc = 0;

    // Reference state: what the driver outputs should be holding right now.
    int         m_wins = 0;
    int         m_losses = 0;
    logic [3:0] m_ival = 4'd0;
    logic [1:0] m_mode = 2'b00;
    logic [1:0] m_res = 2'b00;

    bit w_pat[16];
    bit l_pat[16];

    function automatic int sat(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    // Monitor: every done pulse pops one expected completion.
    exp_t e;
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 expected=0 at cycle %0d", cyc);
            end else begin
                e = exp_q.pop_front();
                check("done_latency", cyc - accept_cyc, e.delta);
                check("init", init, e.init);
                check("i_value", i_value, e.ival);
                check("control", control, e.ctrl);
                check("result", result, e.res);
                check("obs_wins", obs_wins, e.wins);
                check("obs_losses", obs_losses, e.losses);
                check("busy_at_done", busy, 1);
            end
        end
    end

    task automatic check_reset_values();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_init", init, 0);
        check("rst_i_value", i_value, 0);
        check("rst_control", control, 0);
        check("rst_result", result, 0);
        check("rst_obs_wins", obs_wins, 0);
        check("rst_obs_losses", obs_losses, 0);
    endtask

    // Issue one command, push its expected completion, and drive the game status
    // over its lifetime. Junk command traffic is offered throughout the busy period.
    task automatic issue(input bit op, input logic [1:0] mode, input logic [3:0] val,
                         input int g, input logic [1:0] who_v);
        exp_t x;
        int len, gg, n, sw, sl;
        check("cmd_ready_idle", cmd_ready, 1);
        check("busy_idle", busy, 0);
        gg = 0;
        n = 0;
        if (!op) begin
            x.delta = 0; x.init = 1'b1; x.ival = val; x.ctrl = m_mode; x.res = m_res;
            x.wins = sat(m_wins); x.losses = sat(m_losses);
            m_wins = 0; m_losses = 0; m_ival = val;
        end else begin
            len = (val == 0) ? 16 : int'(val);
            gg = (g > len) ? 0 : g;
            n = (gg != 0) ? gg : len;
            sw = 0; sl = 0;
            x.init = 1'b0; x.ival = m_ival; x.ctrl = mode;
            if (gg != 0) begin
                for (int k = 0; k < gg; k++) begin sw += w_pat[k]; sl += l_pat[k]; end
                x.delta = gg; x.res = who_v;
                x.wins = sat(m_wins + sw); x.losses = sat(m_losses + sl);
                m_wins = 0; m_losses = 0; m_res = who_v;
            end else begin
                for (int k = 0; k < len - 1; k++) begin sw += w_pat[k]; sl += l_pat[k]; end
                x.delta = len - 1; x.res = m_res;
                x.wins = sat(m_wins + sw); x.losses = sat(m_losses + sl);
                m_wins += sw + int'(w_pat[len-1]);
                m_losses += sl + int'(l_pat[len-1]);
            end
            m_mode = mode;
        end
        exp_q.push_back(x);

        cmd_valid = 1'b1; cmd_op = op; cmd_mode = mode; cmd_value = val;
        @(posedge clk); #1;
        accept_cyc = cyc;
        cmd_op = 1'($urandom); cmd_mode = 2'($urandom); cmd_value = 4'($urandom);
        if (!op) begin
            win = 1'($urandom); los = 1'($urandom); gameover = 1'($urandom); who = 2'($urandom);
            @(posedge clk); #1;
        end else begin
            for (int k = 0; k < n; k++) begin
                win = w_pat[k]; los = l_pat[k];
                gameover = (gg == k + 1);
                who = gameover ? who_v : 2'($urandom);
                cmd_op = 1'($urandom); cmd_mode = 2'($urandom); cmd_value = 4'($urandom);
                @(posedge clk); #1;
            end
            if (gg != 0) begin
                win = 1'($urandom); los = 1'($urandom); gameover = 1'($urandom); who = 2'($urandom);
                @(posedge clk); #1;
            end
        end
        cmd_valid = 1'b0; win = 1'b0; los = 1'b0; gameover = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_pat(input bit rnd, input bit wv, input bit lv);
        for (int k = 0; k < 16; k++) begin
            w_pat[k] = rnd ? 1'($urandom) : wv;
            l_pat[k] = rnd ? 1'($urandom) : lv;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_values();
        @(negedge clk);

        // INIT 0xE
        issue(1'b0, 2'b00, 4'hE, 0, 2'b00);

        // RUN up1 length 3: win in cycle 1, los in cycle 2
        set_pat(1'b0, 1'b0, 1'b0);
        w_pat[0] = 1'b1; l_pat[1] = 1'b1;
        issue(1'b1, 2'b00, 4'd3, 0, 2'b00);

        // RUN length 0 spans 16 cycles
        set_pat(1'b1, 1'b0, 1'b0);
        issue(1'b1, 2'b01, 4'd0, 0, 2'b00);

        // RUN length 10 with gameover in cycle 2, who = 10
        set_pat(1'b1, 1'b0, 1'b0);
        issue(1'b1, 2'b10, 4'd10, 2, 2'b10);

        // gameover in the final cycle of a run takes priority over expiry
        set_pat(1'b1, 1'b0, 1'b0);
        issue(1'b1, 2'b11, 4'd4, 4, 2'b01);

        // Reset in RUN cycle 4 of a length-8 run with win held high
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_mode = 2'b11; cmd_value = 4'd8;
        @(posedge clk); #1;
        cmd_valid = 1'b0; win = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_values();
        m_wins = 0; m_losses = 0; m_ival = 4'd0; m_mode = 2'b00; m_res = 2'b00;
        win = 1'b0;
        // command offered in the first cycle after reset deasserts
        set_pat(1'b0, 1'b1, 1'b0);
        issue(1'b1, 2'b00, 4'd0, 0, 2'b00);
        // second full-length run with win held: obs_wins pinned at 15
        issue(1'b1, 2'b01, 4'd0, 0, 2'b00);
        issue(1'b0, 2'b00, 4'h5, 0, 2'b00);

        // Randomized command stream
        for (int t = 0; t < 40; t++) begin
            bit         op;
            logic [3:0] v;
            int         len, g;
            op = ($urandom_range(0, 3) != 0);
            v = 4'($urandom);
            len = (v == 0) ? 16 : int'(v);
            g = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, len)) : 0;
            set_pat(1'b1, 1'b0, 1'b0);
            issue(op, 2'($urandom), v, g, 2'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_driver.md
GAME_DRIVER -- requirements
Module: game_driver

Interface
REQ-001 SHALL have parameter COUNTER_SIZE, default 4, meaning the width of i_value and the game counter.
REQ-002 SHALL have port clk  in  1  clock; all logic updates on the rising edge.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port cmd_valid  in  1  command offered.
REQ-005 SHALL have port cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-006 SHALL have port cmd_op  in  1  command opcode: 0 = INIT, 1 = RUN.
REQ-007 SHALL have port cmd_mode  in  2  counter mode for RUN: 00 up1, 01 up2, 10 down1, 11 down2.
REQ-008 SHALL have port cmd_value  in  COUNTER_SIZE  load value (INIT) or run length (RUN).
REQ-009 SHALL have ports init out 1, i_value out COUNTER_SIZE, control out 2: drive to the game block.
REQ-010 SHALL have ports win in 1, los in 1, gameover in 1, who in 2: status from the game block.
REQ-011 SHALL have ports busy out 1, done out 1 (one-cycle pulse), result out 2 (latched who).
REQ-012 SHALL have ports obs_wins out 4 and obs_losses out 4: observed win/loss counts.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, RUN, OVER; cmd_ready = 1 only in IDLE; busy = 1 in every state except IDLE.
REQ-014 SHALL accept a command on an edge with cmd_valid && cmd_ready, capturing cmd_op, cmd_mode and cmd_value; INIT goes to LOAD, RUN goes to RUN.
REQ-015 LOAD SHALL last exactly one cycle and do the following:
- init = 1 and i_value = captured value;
- done = 1 in that cycle;
- obs_wins and obs_losses cleared to 0 at its end;
- next state IDLE.
REQ-016 RUN SHALL last L cycles: init = 0, control = captured mode, L = captured value; L = 0 means 2^COUNTER_SIZE cycles.
REQ-017 In each RUN cycle where win is sampled high, obs_wins SHALL increment, saturating at 15; likewise los increments obs_losses.
REQ-018 done SHALL be 1 in the last RUN cycle when the run length expires without gameover; next state IDLE.
REQ-019 If gameover is sampled high in any RUN cycle, the block SHALL:
- go to OVER next cycle, abandoning the remaining length;
- count the same cycle's win/los first;
- give gameover priority over run-length expiry in the same cycle.
REQ-020 OVER SHALL last one cycle and do the following:
- result = who sampled with gameover;
- done = 1;
- obs counters cleared to 0 at its end;
- next state IDLE.
REQ-021 In IDLE, init SHALL be 0 and control and i_value SHALL hold their last driven values.
REQ-022 win, los and gameover sampled outside RUN SHALL be ignored.
REQ-023 result SHALL hold its value until the next OVER or reset.
REQ-024 cmd_* changes while busy SHALL have no effect.

Reset
REQ-025 reset SHALL override all other activity in the cycle it is sampled.
REQ-026 On reset the block SHALL return to IDLE and set the following output values:
- cmd_ready = 1, busy = 0, done = 0;
- init = 0, i_value = 0, control = 00;
- result = 00, obs_wins = 0, obs_losses = 0.
REQ-027 Reset mid-LOAD, RUN or OVER SHALL abort with no done pulse; a command is acceptable the first cycle after reset deasserts.

Structure
REQ-028 SHALL take the following from shared package game_pkg:
- COUNTER_SIZE default constant;
- cmd_op enum (OP_INIT, OP_RUN);
- mode enum (UP1 = 00, UP2 = 01, DN1 = 10, DN2 = 11);
- state enum (IDLE, LOAD, RUN, OVER).
REQ-029 SHALL instantiate two copies of sub-module game_sat_counter, a 4-bit saturating counter with clear, for obs_wins and obs_losses.

Verification
REQ-030 Reset for 2 cycles -> cmd_ready = 1, busy = 0, init = 0, control = 00, result = 00, both obs counts 0.
REQ-031 INIT with value 4'hE -> next cycle init = 1, i_value = E, done = 1 for exactly one cycle; cmd_ready = 1 the following cycle.
REQ-032 RUN mode 00 length 3, model drives win high in cycle 1 and los high in cycle 2 -> control = 00 for 3 cycles, obs_wins = 1, obs_losses = 1, done in cycle 3.
REQ-033 RUN with length 0 -> exactly 16 RUN cycles, then done, then IDLE.
REQ-034 RUN length 10 with gameover = 1 and who = 10 in cycle 2 -> OVER in cycle 3, result = 10, done pulse, obs counts 0 after, only 2 RUN cycles.
REQ-035 Reset asserted in RUN cycle 4 of length 8, plus win held high for 20 cycles -> reset values next edge, no done pulse, obs_wins saturates at 15 in a separate length-0 run.
